// File: rtl/seq_alu_if.sv
// Operand/request/result bundle between the register-file read ports, control unit and seq_alu.
// The control unit side is the master; the ALU is the slave.
interface seq_alu_if #(
  parameter int DATA_WIDTH = 21
);
  logic                  Alu_Start;
  logic                  Alu_Add;
  logic                  Alu_Sub;
  logic                  Alu_Mul;
  logic                  Alu_Pass;
  logic [DATA_WIDTH-1:0] Reg1_Out;
  logic [DATA_WIDTH-1:0] Reg2_Out;
  logic [DATA_WIDTH-1:0] Alu_Out;
  logic                  Alu_Busy;
  logic                  Alu_Done;
  logic                  Alu_Zero;
  logic                  Alu_Carry;
  logic                  Alu_Overflow;
  logic                  Alu_Err;

  modport master (
    output Alu_Start, Alu_Add, Alu_Sub, Alu_Mul, Alu_Pass, Reg1_Out, Reg2_Out,
    input  Alu_Out, Alu_Busy, Alu_Done, Alu_Zero, Alu_Carry, Alu_Overflow, Alu_Err
  );

  modport slave (
    input  Alu_Start, Alu_Add, Alu_Sub, Alu_Mul, Alu_Pass, Reg1_Out, Reg2_Out,
    output Alu_Out, Alu_Busy, Alu_Done, Alu_Zero, Alu_Carry, Alu_Overflow, Alu_Err
  );
endinterface

// File: rtl/seq_alu.sv
// Clocked ALU with one-hot add/sub/mul/pass, registered result and flags, start/done handshake
// and an iterative shift-add multiplier consuming MUL_STEP multiplier bits per cycle.
module seq_alu #(
  parameter int DATA_WIDTH = 21,
  parameter int MUL_STEP   = 1
) (
  input  logic     Clk,
  input  logic     Rst_n,
  seq_alu_if.slave bus
);
  localparam int STEPS = DATA_WIDTH / MUL_STEP;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int ACC_W = 2 * DATA_WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] a_reg, a_next;
  logic [ACC_W-1:0]      b_reg, b_next;
  logic [ACC_W-1:0]      acc_reg, acc_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0] out_reg, out_next;
  logic                  done_reg, done_next;
  logic                  err_reg, err_next;
  logic                  zero_reg, zero_next;
  logic                  carry_reg, carry_next;
  logic                  ovf_reg, ovf_next;

  // Multiplier: a_reg shifts right and b_reg shifts left, so each step only
  // looks at the low MUL_STEP bits of a_reg against an already-aligned b_reg.
  logic [ACC_W-1:0] pp_term [MUL_STEP];
  logic [ACC_W-1:0] pp_sum;
  logic [ACC_W-1:0] mul_total;

  genvar gi;
  generate
    for (gi = 0; gi < MUL_STEP; gi++) begin : g_pp
      assign pp_term[gi] = a_reg[gi] ? (b_reg << gi) : '0;
    end
  endgenerate

  always_comb begin
    pp_sum = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      pp_sum = pp_sum + pp_term[i];
    end
  end

  assign mul_total = acc_reg + pp_sum;

  logic [DATA_WIDTH:0]   add_full;
  logic [DATA_WIDTH:0]   sub_full;
  logic                  sel_onehot;
  logic [DATA_WIDTH-1:0] mul_low;

  assign add_full   = {1'b0, bus.Reg1_Out} + {1'b0, bus.Reg2_Out};
  assign sub_full   = {1'b0, bus.Reg1_Out} + {1'b0, ~bus.Reg2_Out} + {{DATA_WIDTH{1'b0}}, 1'b1};
  assign sel_onehot = $onehot({bus.Alu_Add, bus.Alu_Sub, bus.Alu_Mul, bus.Alu_Pass});
  assign mul_low    = mul_total[DATA_WIDTH-1:0];

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    out_next   = out_reg;
    zero_next  = zero_reg;
    carry_next = carry_reg;
    ovf_next   = ovf_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.Alu_Start) begin
          if (!sel_onehot) begin
            done_next = 1'b1;
            err_next  = 1'b1;
          end else if (bus.Alu_Mul) begin
            state_next = MUL;
            a_next     = bus.Reg1_Out;
            b_next     = {{DATA_WIDTH{1'b0}}, bus.Reg2_Out};
            acc_next   = '0;
            cnt_next   = '0;
          end else begin
            done_next = 1'b1;
            if (bus.Alu_Add) begin
              out_next   = add_full[DATA_WIDTH-1:0];
              carry_next = add_full[DATA_WIDTH];
              ovf_next   = (bus.Reg1_Out[DATA_WIDTH-1] == bus.Reg2_Out[DATA_WIDTH-1]) &&
                           (add_full[DATA_WIDTH-1] != bus.Reg1_Out[DATA_WIDTH-1]);
            end else if (bus.Alu_Sub) begin
              out_next   = sub_full[DATA_WIDTH-1:0];
              carry_next = ~sub_full[DATA_WIDTH];
              ovf_next   = (bus.Reg1_Out[DATA_WIDTH-1] != bus.Reg2_Out[DATA_WIDTH-1]) &&
                           (sub_full[DATA_WIDTH-1] != bus.Reg1_Out[DATA_WIDTH-1]);
            end else begin
              out_next   = bus.Reg2_Out;
              carry_next = 1'b0;
              ovf_next   = 1'b0;
            end
            zero_next = (out_next == '0);
          end
        end
      end
      MUL: begin
        acc_next = mul_total;
        a_next   = a_reg >> MUL_STEP;
        b_next   = b_reg << MUL_STEP;
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == LAST_CNT) begin
          state_next = IDLE;
          out_next   = mul_low;
          carry_next = |mul_total[ACC_W-1:DATA_WIDTH];
          ovf_next   = |mul_total[ACC_W-1:DATA_WIDTH];
          zero_next  = (mul_low == '0);
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      out_reg   <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      zero_reg  <= 1'b0;
      carry_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      out_reg   <= out_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      zero_reg  <= zero_next;
      carry_reg <= carry_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign bus.Alu_Out      = out_reg;
  assign bus.Alu_Busy     = (state_reg == MUL);
  assign bus.Alu_Done     = done_reg;
  assign bus.Alu_Err      = err_reg;
  assign bus.Alu_Zero     = zero_reg;
  assign bus.Alu_Carry    = carry_reg;
  assign bus.Alu_Overflow = ovf_reg;
endmodule
